// File: rtl/fft_frame_src_if.sv
// Sample-memory read port plus AXI-Stream output of the FFT frame source.
// master = frame source side, slave = memory/FFT side.
interface fft_frame_src_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2
);
  logic                mem_rd_en;
  logic [BANK_W-1:0]   mem_bank;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2*DATA_W-1:0] mem_rd_data;

  logic [2*DATA_W-1:0] m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic [BANK_W-1:0]   m_axis_tuser;

  modport master (
    output mem_rd_en, mem_bank, mem_addr,
    input  mem_rd_data,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    input  mem_rd_en, mem_bank, mem_addr,
    output mem_rd_data,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/fft_frame_src.sv
// Banked frame source for the FFT AXI-Stream input; one frame per bank, then waits for fft_done.
// Define FRAME_SRC_REAL_ONLY_EN to zero the Q half of every output beat.
module fft_frame_src #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  input  logic               stop,
  input  logic [BANK_W-1:0]  start_bank,
  input  logic [ADDR_W-1:0]  frame_len_m1,
  input  logic               fft_done,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  fft_frame_src_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_DONE} state_t;

  state_t              state_reg;
  logic                cont_reg;
  logic                stop_reg;
  logic [BANK_W-1:0]   bank_reg;
  logic [ADDR_W-1:0]   len_m1_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic                rd_done_reg;
  logic                rd_last_reg;
  logic                data_vld_reg;
  logic                data_last_reg;
  logic [2*DATA_W-1:0] fifo_data_reg [2];
  logic                fifo_last_reg [2];
  logic                fifo_wr_ptr_reg;
  logic                fifo_rd_ptr_reg;
  logic [1:0]          fifo_cnt_reg;

  logic [1:0]          fifo_cnt_next;
  logic [2*DATA_W-1:0] rd_word;
  logic [BANK_W-1:0]   start_bank_safe;
  logic [BANK_W-1:0]   bank_next;
  logic                out_free;
  logic                beat_pop;
  logic                fifo_pop;
  logic                fifo_push;
  logic                bypass;
  logic                can_issue;

`ifdef FRAME_SRC_REAL_ONLY_EN
  assign rd_word = {{DATA_W{1'b0}}, bus.mem_rd_data[DATA_W-1:0]};
`else
  assign rd_word = bus.mem_rd_data;
`endif

  assign start_bank_safe = (int'(start_bank) < NUM_BANKS) ? start_bank : '0;
  assign bank_next       = (int'(bank_reg) >= NUM_BANKS - 1) ? '0 : bank_reg + 1'b1;

  // Output register sits in front of the 2-entry FIFO; returning data bypasses
  // the FIFO whenever it is empty and the output stage is free.
  assign beat_pop  = bus.m_axis_tvalid & bus.m_axis_tready;
  assign out_free  = ~bus.m_axis_tvalid | bus.m_axis_tready;
  assign fifo_pop  = out_free & (fifo_cnt_reg != 2'd0);
  assign bypass    = out_free & (fifo_cnt_reg == 2'd0) & data_vld_reg;
  assign fifo_push = data_vld_reg & ~bypass;

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    if (fifo_push && !fifo_pop)
      fifo_cnt_next = fifo_cnt_reg + 2'd1;
    else if (!fifo_push && fifo_pop)
      fifo_cnt_next = fifo_cnt_reg - 2'd1;
  end

  // Credit check: FIFO entries after this edge plus the read still on its way
  // must leave room for the new read even if the sink stalls from now on.
  assign can_issue = (fifo_cnt_next + {1'b0, bus.mem_rd_en}) < 2'd2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      cont_reg          <= 1'b0;
      stop_reg          <= 1'b0;
      bank_reg          <= '0;
      len_m1_reg        <= '0;
      rd_addr_reg       <= '0;
      rd_done_reg       <= 1'b0;
      rd_last_reg       <= 1'b0;
      data_vld_reg      <= 1'b0;
      data_last_reg     <= 1'b0;
      fifo_wr_ptr_reg   <= 1'b0;
      fifo_rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg      <= 2'd0;
      bus.mem_rd_en     <= 1'b0;
      bus.mem_bank      <= '0;
      bus.mem_addr      <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tuser  <= '0;
      busy              <= 1'b0;
      frame_cnt         <= 16'd0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      data_vld_reg  <= bus.mem_rd_en;
      data_last_reg <= rd_last_reg;

      if (fifo_push) begin
        fifo_data_reg[fifo_wr_ptr_reg] <= rd_word;
        fifo_last_reg[fifo_wr_ptr_reg] <= data_last_reg;
        fifo_wr_ptr_reg                <= ~fifo_wr_ptr_reg;
      end
      if (fifo_pop)
        fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_next;

      if (out_free) begin
        if (fifo_pop) begin
          bus.m_axis_tvalid <= 1'b1;
          bus.m_axis_tdata  <= fifo_data_reg[fifo_rd_ptr_reg];
          bus.m_axis_tlast  <= fifo_last_reg[fifo_rd_ptr_reg];
          bus.m_axis_tuser  <= bank_reg;
        end else if (bypass) begin
          bus.m_axis_tvalid <= 1'b1;
          bus.m_axis_tdata  <= rd_word;
          bus.m_axis_tlast  <= data_last_reg;
          bus.m_axis_tuser  <= bank_reg;
        end else begin
          bus.m_axis_tvalid <= 1'b0;
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cont_reg      <= continuous;
            len_m1_reg    <= frame_len_m1;
            bank_reg      <= start_bank_safe;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= '0;
            bus.mem_bank  <= start_bank_safe;
            rd_addr_reg   <= ADDR_W'(1);
            rd_done_reg   <= (frame_len_m1 == '0);
            rd_last_reg   <= (frame_len_m1 == '0);
            busy          <= 1'b1;
            state_reg     <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (stop)
            stop_reg <= 1'b1;
          if (!rd_done_reg && can_issue) begin
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= rd_addr_reg;
            bus.mem_bank  <= bank_reg;
            rd_addr_reg   <= rd_addr_reg + 1'b1;
            rd_done_reg   <= (rd_addr_reg == len_m1_reg);
            rd_last_reg   <= (rd_addr_reg == len_m1_reg);
          end
          if (beat_pop && bus.m_axis_tlast)
            state_reg <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (stop)
            stop_reg <= 1'b1;
          if (fft_done) begin
            frame_cnt <= frame_cnt + 16'd1;
            bank_reg  <= bank_next;
            if (cont_reg && !stop_reg && !stop) begin
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= '0;
              bus.mem_bank  <= bank_next;
              rd_addr_reg   <= ADDR_W'(1);
              rd_done_reg   <= (len_m1_reg == '0);
              rd_last_reg   <= (len_m1_reg == '0);
              state_reg     <= S_STREAM;
            end else begin
              stop_reg  <= 1'b0;
              busy      <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_src.sv
// Directed self-checking bench for fft_frame_src: reset, one-shot, backpressure,
// continuous banks with stop, single-beat frame and mid-frame reset.
module tb_fft_frame_src;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 14;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               continuous = 1'b0;
  logic               stop = 1'b0;
  logic               fft_done = 1'b0;
  logic [BANK_W-1:0]  start_bank = '0;
  logic [ADDR_W-1:0]  frame_len_m1 = '0;
  logic               busy;
  logic [15:0]        frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  logic [31:0] cyc = 0;

  fft_frame_src_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

  fft_frame_src #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .stop         (stop),
    .start_bank   (start_bank),
    .frame_len_m1 (frame_len_m1),
    .fft_done     (fft_done),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample memory: 1-cycle latency, word = {Q=DEADBEEF, I=A5_bank_addr}
  always @(posedge clk)
    if (bus.mem_rd_en)
      bus.mem_rd_data <= {32'hDEADBEEF, 8'hA5, 6'd0, bus.mem_bank, 2'b00, bus.mem_addr};

  initial bus.m_axis_tready = 1'b0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  user;
    logic [31:0] cyc;
  } beat_t;

  beat_t beats[$];
  beat_t mon_beat;
  int    issued = 0;
  int    accepted = 0;
  int    stable_err = 0;
  int    over_err = 0;
  logic  stall_prev = 1'b0;
  logic [66:0] hold_reg = '0;

  // Monitor: records accepted beats, checks hold-while-stalled and outstanding count.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
      issued     <= accepted;
    end else begin
      if (bus.mem_rd_en) issued <= issued + 1;
      if (stall_prev && (!bus.m_axis_tvalid ||
          {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser} !== hold_reg))
        stable_err <= stable_err + 1;
      if ((issued + int'(bus.mem_rd_en) - accepted - int'(bus.m_axis_tvalid)) > 2)
        over_err <= over_err + 1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        mon_beat.data = bus.m_axis_tdata;
        mon_beat.last = bus.m_axis_tlast;
        mon_beat.user = bus.m_axis_tuser;
        mon_beat.cyc  = cyc;
        beats.push_back(mon_beat);
        accepted <= accepted + 1;
      end
      stall_prev <= bus.m_axis_tvalid && !bus.m_axis_tready;
      hold_reg   <= {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
    end
  end

  function automatic logic [63:0] exp_word(input logic [1:0] b, input int a);
    logic [31:0] i_w;
    i_w = {8'hA5, 6'd0, b, 2'b00, a[13:0]};
`ifdef FRAME_SRC_REAL_ONLY_EN
    return {32'h0, i_w};
`else
    return {32'hDEADBEEF, i_w};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; continuous = 1'b1; frame_len_m1 = 14'd5;
    repeat (3) tick();
    total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b want=0", bus.mem_rd_en); end
    total++; if (bus.mem_bank !== 2'd0) begin bad++; $display("FAIL rst_bank got=%0d want=0", bus.mem_bank); end
    total++; if (bus.mem_addr !== 14'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", bus.mem_addr); end
    total++; if (bus.m_axis_tdata !== 64'd0) begin bad++; $display("FAIL rst_tdata got=%h want=0", bus.m_axis_tdata); end
    total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", bus.m_axis_tvalid); end
    total++; if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", bus.m_axis_tlast); end
    total++; if (bus.m_axis_tuser !== 2'd0) begin bad++; $display("FAIL rst_tuser got=%0d want=0", bus.m_axis_tuser); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d want=0", frame_cnt); end
    start = 1'b0; continuous = 1'b0; rst_n = 1'b1;
    tick();
    $display("test_reset: outputs checked after 3 reset cycles");
  endtask

  task automatic test_one_shot();
    int base = beats.size();
    start_bank = 2'd2; frame_len_m1 = 14'd7; continuous = 1'b0; bus.m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 14'd0 || bus.mem_bank !== 2'd2) begin
      bad++; $display("FAIL os_first_read got en=%b addr=%0d bank=%0d want en=1 addr=0 bank=2", bus.mem_rd_en, bus.mem_addr, bus.mem_bank); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy got=%b want=1", busy); end
    tick();
    total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL os_tvalid_e1 got=%b want=0", bus.m_axis_tvalid); end
    tick();
    total++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== exp_word(2'd2, 0)) begin
      bad++; $display("FAIL os_first_beat got v=%b d=%h want v=1 d=%h", bus.m_axis_tvalid, bus.m_axis_tdata, exp_word(2'd2, 0)); end
    for (int n = 0; n < 50 && beats.size() < base + 8; n++) tick();
    total++; if (beats.size() != base + 8) begin bad++; $display("FAIL os_count got=%0d want=8", beats.size() - base); end
    for (int i = 0; i < 8 && base + i < beats.size(); i++) begin
      total++;
      if (beats[base+i].data !== exp_word(2'd2, i) || beats[base+i].user !== 2'd2 ||
          beats[base+i].last !== (i == 7) || beats[base+i].cyc !== beats[base].cyc + i) begin
        bad++; $display("FAIL os_beat%0d got d=%h u=%0d l=%b dc=%0d want d=%h u=2 l=%b dc=%0d", i,
          beats[base+i].data, beats[base+i].user, beats[base+i].last, beats[base+i].cyc - beats[base].cyc,
          exp_word(2'd2, i), (i == 7), i);
      end
    end
    repeat (5) tick();
    total++; if (busy !== 1'b1 || bus.m_axis_tvalid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL os_wait got busy=%b v=%b rd=%b want busy=1 v=0 rd=0", busy, bus.m_axis_tvalid, bus.mem_rd_en); end
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL os_cnt_before got=%0d want=%0d", frame_cnt, exp_frames); end
    pulse_done();
    exp_frames++;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_busy_end got=%b want=0", busy); end
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL os_cnt_after got=%0d want=%0d", frame_cnt, exp_frames); end
    $display("test_one_shot: %0d beats from bank 2", beats.size() - base);
  endtask

  task automatic test_backpressure();
    logic pat [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int base = beats.size();
    int se0 = stable_err;
    int oe0 = over_err;
    start_bank = 2'd1; frame_len_m1 = 14'd15; continuous = 1'b0;
    start = 1'b1; bus.m_axis_tready = pat[0];
    tick();
    start = 1'b0;
    for (int k = 1; k < 400 && beats.size() < base + 16; k++) begin
      bus.m_axis_tready = pat[k % 12];
      tick();
    end
    bus.m_axis_tready = 1'b1;
    total++; if (beats.size() != base + 16) begin bad++; $display("FAIL bp_count got=%0d want=16", beats.size() - base); end
    for (int i = 0; i < 16 && base + i < beats.size(); i++) begin
      total++;
      if (beats[base+i].data !== exp_word(2'd1, i) || beats[base+i].user !== 2'd1 || beats[base+i].last !== (i == 15)) begin
        bad++; $display("FAIL bp_beat%0d got d=%h u=%0d l=%b want d=%h u=1 l=%b", i,
          beats[base+i].data, beats[base+i].user, beats[base+i].last, exp_word(2'd1, i), (i == 15));
      end
    end
    total++; if (stable_err != se0) begin bad++; $display("FAIL bp_stable got=%0d violations want=0", stable_err - se0); end
    total++; if (over_err != oe0) begin bad++; $display("FAIL bp_outstanding got=%0d violations want=0", over_err - oe0); end
    repeat (3) tick();
    pulse_done();
    exp_frames++;
    total++; if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin
      bad++; $display("FAIL bp_end got cnt=%0d busy=%b want cnt=%0d busy=0", frame_cnt, busy, exp_frames); end
    $display("test_backpressure: %0d beats under stalls", beats.size() - base);
  endtask

  task automatic test_continuous();
    logic [1:0] bseq [3] = '{2'd3, 2'd0, 2'd1};
    int base = beats.size();
    start_bank = 2'd3; frame_len_m1 = 14'd3; continuous = 1'b1; bus.m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_done();  // arrives while streaming: must be ignored
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 50 && beats.size() < base + 4*(f+1); n++) tick();
      total++; if (beats.size() != base + 4*(f+1)) begin bad++; $display("FAIL ct_frame%0d_count got=%0d want=%0d", f, beats.size() - base, 4*(f+1)); end
      total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL ct_frame%0d_cnt_hold got=%0d want=%0d", f, frame_cnt, exp_frames); end
      repeat (2) tick();
      total++; if (bus.mem_rd_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ct_frame%0d_wait got rd=%b busy=%b want rd=0 busy=1", f, bus.mem_rd_en, busy); end
      pulse_done();
      exp_frames++;
      total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL ct_frame%0d_cnt got=%0d want=%0d", f, frame_cnt, exp_frames); end
      if (f < 2) begin
        total++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 14'd0 || bus.mem_bank !== bseq[f+1] || busy !== 1'b1) begin
          bad++; $display("FAIL ct_next%0d got rd=%b addr=%0d bank=%0d busy=%b want rd=1 addr=0 bank=%0d busy=1",
            f, bus.mem_rd_en, bus.mem_addr, bus.mem_bank, busy, bseq[f+1]);
        end
        if (f == 1) begin
          tick();
          stop = 1'b1;
          tick();
          stop = 1'b0;
        end
      end else begin
        total++; if (busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL ct_idle got busy=%b rd=%b want busy=0 rd=0", busy, bus.mem_rd_en); end
      end
    end
    for (int i = 0; i < 12 && base + i < beats.size(); i++) begin
      total++;
      if (beats[base+i].data !== exp_word(bseq[i/4], i % 4) || beats[base+i].user !== bseq[i/4] ||
          beats[base+i].last !== ((i % 4) == 3)) begin
        bad++; $display("FAIL ct_beat%0d got d=%h u=%0d l=%b want d=%h u=%0d l=%b", i, beats[base+i].data,
          beats[base+i].user, beats[base+i].last, exp_word(bseq[i/4], i % 4), bseq[i/4], ((i % 4) == 3));
      end
    end
    repeat (6) tick();
    total++; if (beats.size() != base + 12) begin bad++; $display("FAIL ct_no_extra got=%0d want=12", beats.size() - base); end
    continuous = 1'b0;
    $display("test_continuous: %0d beats over banks 3,0,1", beats.size() - base);
  endtask

  task automatic test_edge_reset();
    int base = beats.size();
    start_bank = 2'd0; frame_len_m1 = 14'd0; continuous = 1'b0; bus.m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && beats.size() < base + 1; n++) tick();
    repeat (4) tick();
    total++; if (beats.size() != base + 1) begin bad++; $display("FAIL len1_count got=%0d want=1", beats.size() - base); end
    if (beats.size() > base) begin
      total++;
      if (beats[base].data !== exp_word(2'd0, 0) || beats[base].last !== 1'b1 || beats[base].user !== 2'd0) begin
        bad++; $display("FAIL len1_beat got d=%h l=%b u=%0d want d=%h l=1 u=0", beats[base].data, beats[base].last, beats[base].user, exp_word(2'd0, 0));
      end
    end
    pulse_done();
    exp_frames++;
    total++; if (frame_cnt !== 16'(exp_frames)) begin bad++; $display("FAIL len1_cnt got=%0d want=%0d", frame_cnt, exp_frames); end

    base = beats.size();
    start_bank = 2'd1; frame_len_m1 = 14'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && beats.size() < base + 5; n++) tick();
    total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mr_beat5_valid got=%b want=1", bus.m_axis_tvalid); end
    rst_n = 1'b0;
    tick();
    exp_frames = 0;
    total++; if (busy !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || bus.mem_rd_en !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL mr_reset got busy=%b v=%b rd=%b cnt=%0d want 0 0 0 0", busy, bus.m_axis_tvalid, bus.mem_rd_en, frame_cnt); end
    rst_n = 1'b1;
    repeat (8) tick();
    total++; if (beats.size() != base + 5) begin bad++; $display("FAIL mr_no_stale got=%0d want=5", beats.size() - base); end
    total++; if (bus.m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_idle got v=%b busy=%b want 0 0", bus.m_axis_tvalid, busy); end
    $display("test_edge_reset: single-beat frame and mid-frame reset done");
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_backpressure();
    test_continuous();
    test_edge_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
